// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I field packer with range check and address-tagged output FIFO
//
// Packs decoded instruction fields plus a signed immediate into 32-bit RV32I
// words. Legal words are queued together with their sequential address.
// Bundles whose format is reserved, or whose immediate cannot be represented,
// still complete the handshake. They are counted as errors and are not written.
//
// Optional feature macro: ROUNDTRIP_CHECK_EN
//   When defined, each written word has its immediate extracted again and
//   compared with the input imm. A difference sets the sticky output rt_mismatch.
//
// Parameters: DEPTH (FIFO words, power of 2, >=2), ADDR_W, BASE_ADDR
// Ports:
//   clk, rst (async, active-high), flush (sync clear)
//   in_valid/in_ready, fmt[2:0], rd/rs1/rs2[4:0], funct3[2:0], funct7[6:0], imm[31:0]
//   out_valid/out_ready, out_instr[31:0], out_addr[ADDR_W-1:0]
//   err (sticky), err_cnt[7:0] (saturating), rt_mismatch (ROUNDTRIP_CHECK_EN only)
module instr_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_cnt
`ifdef ROUNDTRIP_CHECK_EN
  ,
  output logic              rt_mismatch
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic                err_q, err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  // FIFO storage: not reset, the outputs are masked while the FIFO is empty.
  logic [31:0]         mem_instr [DEPTH];
  logic [ADDR_W-1:0]   mem_addr  [DEPTH];

  logic signed [31:0]  imm_s;
  logic                fits_12, fits_b, fits_j;
  logic [31:0]         word;
  logic                legal;
  logic                accept, push, pop, reject;

  assign imm_s   = $signed(imm);
  assign fits_12 = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign fits_b  = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm[0];
  assign fits_j  = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm[0];

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (fmt)
      3'd0: begin word = {funct7, rs2, rs1, funct3, rd, OP_R};    legal = 1'b1;    end
      3'd1: begin word = {imm[11:0], rs1, funct3, rd, OP_I};      legal = fits_12; end
      3'd2: begin word = {imm[11:0], rs1, funct3, rd, OP_L};      legal = fits_12; end
      3'd3: begin word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S}; legal = fits_12; end
      3'd4: begin
        word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
        legal = fits_b;
      end
      3'd5: begin
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        legal = fits_j;
      end
      3'd6: begin word = {imm[11:0], rs1, funct3, rd, OP_JALR};   legal = fits_12; end
      default: begin word = '0; legal = 1'b0; end
    endcase
  end

  // Anything accepted during a flush cycle is dropped, rejected bundles included.
  assign accept = in_valid && (state_q != S_FULL) && !flush;
  assign push   = accept && legal;
  assign reject = accept && !legal;
  assign pop    = out_ready && (state_q != S_EMPTY) && !flush;

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    next_addr_d = push ? next_addr_q + ADDR_W'(4) : next_addr_q;
    err_d       = err_q | reject;
    err_cnt_d   = (reject && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      next_addr_d = BASE_ADDR;
      err_d       = 1'b0;
      err_cnt_d   = '0;
    end
    if (count_d == '0)                state_d = S_EMPTY;
    else if (count_d == CNT_W'(DEPTH)) state_d = S_FULL;
    else                              state_d = S_PARTIAL;
    out_valid_d = (state_d != S_EMPTY);
    in_ready_d  = (state_d != S_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      next_addr_q <= BASE_ADDR;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      next_addr_q <= next_addr_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr_q] <= word;
      mem_addr[wr_ptr_q]  <= next_addr_q;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_instr = out_valid_q ? mem_instr[rd_ptr_q] : '0;
  // With an empty FIFO the address output shows where the next word will land.
  assign out_addr  = out_valid_q ? mem_addr[rd_ptr_q] : next_addr_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

`ifdef ROUNDTRIP_CHECK_EN
  logic [31:0] dec_imm;
  logic        rt_bad;
  logic        rt_mismatch_q, rt_mismatch_d;

  // Independent immediate extraction, as the core's immediate generator would do it.
  always_comb begin
    dec_imm = '0;
    case (fmt)
      3'd1, 3'd2, 3'd6: dec_imm = {{20{word[31]}}, word[31:20]};
      3'd3: dec_imm = {{20{word[31]}}, word[31:25], word[11:7]};
      3'd4: dec_imm = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
      3'd5: dec_imm = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
      default: dec_imm = '0;
    endcase
    rt_bad        = push && (fmt != 3'd0) && (dec_imm != imm);
    rt_mismatch_d = flush ? 1'b0 : (rt_mismatch_q | rt_bad);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rt_mismatch_q <= 1'b0;
    else     rt_mismatch_q <= rt_mismatch_d;
  end

  assign rt_mismatch = rt_mismatch_q;
`endif

endmodule
